// File: rtl/arena_pkg.sv
// rtl/arena_pkg.sv - arena geometry, cell codes, colours and address helper
package arena_pkg;

   localparam int COLS       = 80;
   localparam int ROWS       = 60;
   localparam int CELLS      = COLS * ROWS;
   localparam int CELL_SHIFT = 3;
   localparam int H_PIX      = 640;
   localparam int V_PIX      = 480;
   localparam int ADDR_W     = 13;

   localparam logic [1:0] CELL_VAZIO  = 2'd0;
   localparam logic [1:0] CELL_J1     = 2'd1;
   localparam logic [1:0] CELL_J2     = 2'd2;
   localparam logic [1:0] CELL_PAREDE = 2'd3;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam rgb_t RGB_VAZIO  = 24'h000000;
   localparam rgb_t RGB_J1     = 24'hFFFF00;
   localparam rgb_t RGB_J2     = 24'h00FFFF;
   localparam rgb_t RGB_PAREDE = 24'hFF0000;

   typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

   // row*80 as (row<<6)+(row<<4); callers mask out-of-range coordinates themselves
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] col, input logic [6:0] row);
      logic [ADDR_W-1:0] r13;
      r13 = {6'd0, row};
      return (r13 << 6) + (r13 << 4) + {6'd0, col};
   endfunction

   function automatic rgb_t cell_rgb(input logic [1:0] code);
      case (code)
         CELL_J1:     return RGB_J1;
         CELL_J2:     return RGB_J2;
         CELL_PAREDE: return RGB_PAREDE;
         default:     return RGB_VAZIO;
      endcase
   endfunction

endpackage

// File: rtl/arena_leitor_if.sv
// rtl/arena_leitor_if.sv - trail-grid write and collision-query bus
interface arena_leitor_if;
   logic       wr_en;
   logic [6:0] wr_col;
   logic [5:0] wr_row;
   logic [1:0] wr_val;
   logic       chk_req;
   logic [6:0] chk_col;
   logic [5:0] chk_row;
   logic       chk_ack;
   logic [1:0] chk_val;

   modport master (
      output wr_en, wr_col, wr_row, wr_val, chk_req, chk_col, chk_row,
      input  chk_ack, chk_val
   );

   modport slave (
      input  wr_en, wr_col, wr_row, wr_val, chk_req, chk_col, chk_row,
      output chk_ack, chk_val
   );
endinterface

// File: rtl/arena_ram.sv
// rtl/arena_ram.sv - 4800x2 cell store, one write port and two registered read ports
module arena_ram
   import arena_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [1:0]        wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [1:0]        rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [1:0]        rdata_b
);

   logic [1:0] mem [0:CELLS-1];

   // Reads see the contents before this edge's write (read-before-write).
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
   end

endmodule

// File: rtl/arena_leitor.sv
// rtl/arena_leitor.sv - arena cell map: clear sweep, write/query port and VGA scan colour
module arena_leitor
   import arena_pkg::*;
(
   input  logic          VGA_CLK,
   input  logic          reset,
   input  logic          reiniciar,
   arena_leitor_if.slave bus,
   input  logic [9:0]    next_x,
   input  logic [9:0]    next_y,
   output logic [7:0]    OUT_R,
   output logic [7:0]    OUT_G,
   output logic [7:0]    OUT_B,
   output logic          busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
   localparam logic [6:0]        COL_LIM   = 7'(COLS);
   localparam logic [5:0]        ROW_LIM   = 6'(ROWS);
   localparam logic [9:0]        X_LIM     = 10'(H_PIX);
   localparam logic [9:0]        Y_LIM     = 10'(V_PIX);

   state_t            state, state_next;
   logic [ADDR_W-1:0] clr_addr, clr_next;

   logic              ram_we;
   logic [ADDR_W-1:0] waddr, raddr_a, raddr_b;
   logic [1:0]        wdata, rdata_a, rdata_b;
   logic              wr_in, chk_in, scan_in;
   logic              chk_ack_q, chk_oor, blank;

   always_ff @(posedge VGA_CLK) begin
      if (!reset) begin
         state    <= CLEAR;
         clr_addr <= '0;
      end else begin
         state    <= state_next;
         clr_addr <= clr_next;
      end
   end

   always_comb begin
      state_next = state;
      clr_next   = clr_addr;
      case (state)
         CLEAR: begin
            if (reiniciar) begin
               clr_next = '0;
            end else if (clr_addr == LAST_ADDR) begin
               state_next = IDLE;
               clr_next   = '0;
            end else begin
               clr_next = clr_addr + 1'b1;
            end
         end
         IDLE: begin
            if (reiniciar) begin
               state_next = CLEAR;
               clr_next   = '0;
            end
         end
         default: begin
            state_next = CLEAR;
            clr_next   = '0;
         end
      endcase
   end

   assign busy = (state == CLEAR);

   // The sweep owns the write port while busy; player writes and queries are ignored then.
   always_comb begin
      wr_in   = (bus.wr_col < COL_LIM) && (bus.wr_row < ROW_LIM);
      chk_in  = (bus.chk_col < COL_LIM) && (bus.chk_row < ROW_LIM);
      scan_in = (next_x < X_LIM) && (next_y < Y_LIM);
      ram_we  = busy || (bus.wr_en && wr_in);
      waddr   = busy ? clr_addr : cell_addr(bus.wr_col, {1'b0, bus.wr_row});
      wdata   = busy ? CELL_VAZIO : bus.wr_val;
      raddr_a = chk_in ? cell_addr(bus.chk_col, {1'b0, bus.chk_row}) : '0;
      raddr_b = scan_in ? cell_addr(next_x[9:CELL_SHIFT], next_y[9:CELL_SHIFT]) : '0;
   end

   arena_ram u_ram (
      .clk     (VGA_CLK),
      .we      (ram_we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr_a (raddr_a),
      .rdata_a (rdata_a),
      .raddr_b (raddr_b),
      .rdata_b (rdata_b)
   );

   // blank travels alongside the RAM read so busy and off-screen forcing share the 2-cycle latency
   always_ff @(posedge VGA_CLK) begin
      if (!reset) begin
         chk_ack_q <= 1'b0;
         chk_oor   <= 1'b0;
         blank     <= 1'b1;
         OUT_R     <= '0;
         OUT_G     <= '0;
         OUT_B     <= '0;
      end else begin
         chk_ack_q <= !busy && bus.chk_req;
         chk_oor   <= !chk_in;
         blank     <= busy || !scan_in;
         {OUT_R, OUT_G, OUT_B} <= blank ? RGB_VAZIO : cell_rgb(rdata_b);
      end
   end

   assign bus.chk_ack = chk_ack_q;
   assign bus.chk_val = !chk_ack_q ? CELL_VAZIO : (chk_oor ? CELL_PAREDE : rdata_a);

endmodule

// File: tb/tb_arena_leitor.sv
// tb/tb_arena_leitor.sv - randomized self-checking bench for arena_leitor
module tb_arena_leitor;

   logic       clk = 1'b0;
   logic       reset;
   logic       reiniciar;
   logic [9:0] next_x, next_y;
   logic [7:0] out_r, out_g, out_b;
   logic       busy;

   int checks = 0;
   int failures = 0;

   logic [1:0] model [0:59][0:79];

   arena_leitor_if bus();

   arena_leitor dut (
      .VGA_CLK   (clk),
      .reset     (reset),
      .reiniciar (reiniciar),
      .bus       (bus),
      .next_x    (next_x),
      .next_y    (next_y),
      .OUT_R     (out_r),
      .OUT_G     (out_g),
      .OUT_B     (out_b),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.wr_en   = 1'b0;
      bus.wr_col  = '0;
      bus.wr_row  = '0;
      bus.wr_val  = '0;
      bus.chk_req = 1'b0;
      bus.chk_col = '0;
      bus.chk_row = '0;
      reiniciar   = 1'b0;
   endtask

   task automatic model_clear;
      for (int r = 0; r < 60; r++)
         for (int c = 0; c < 80; c++)
            model[r][c] = 2'd0;
   endtask

   function automatic logic [23:0] exp_rgb(input int x, input int y);
      if (x >= 640 || y >= 480) return 24'h000000;
      case (model[y / 8][x / 8])
         2'd1:    return 24'hFFFF00;
         2'd2:    return 24'h00FFFF;
         2'd3:    return 24'hFF0000;
         default: return 24'h000000;
      endcase
   endfunction

   task automatic do_write(input int col, input int row, input logic [1:0] val);
      bus.wr_en  = 1'b1;
      bus.wr_col = 7'(col);
      bus.wr_row = 6'(row);
      bus.wr_val = val;
      tick();
      bus.wr_en = 1'b0;
      if (col < 80 && row < 60) model[row][col] = val;
   endtask

   task automatic do_query(input int col, input int row);
      bus.chk_req = 1'b1;
      bus.chk_col = 7'(col);
      bus.chk_row = 6'(row);
      tick();
      bus.chk_req = 1'b0;
   endtask

   task automatic scan_pixel(input int x, input int y);
      next_x = 10'(x);
      next_y = 10'(y);
      tick();
      tick();
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 10000) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset;
      int cnt;
      int bad_out;
      reset = 1'b0;
      idle_inputs();
      tick();
      reset = 1'b1;
      checks++;
      if (busy !== 1'b1 || {out_r, out_g, out_b} !== 24'h0 || bus.chk_ack !== 1'b0 || bus.chk_val !== 2'd0) begin
         failures++;
         $display("FAIL reset_values busy=%b rgb=%h ack=%b val=%0d want busy=1 rgb=0 ack=0 val=0",
                  busy, {out_r, out_g, out_b}, bus.chk_ack, bus.chk_val);
      end
      cnt = 1;
      bad_out = 0;
      while (busy && cnt < 10000) begin
         tick();
         if (busy) cnt++;
         if ({out_r, out_g, out_b} !== 24'h0) bad_out++;
      end
      model_clear();
      checks++;
      if (cnt !== 4800) begin
         failures++;
         $display("FAIL reset_busy_len got=%0d want=4800", cnt);
      end
      checks++;
      if (bad_out !== 0) begin
         failures++;
         $display("FAIL reset_black got=%0d nonblack cycles want=0", bad_out);
      end
      do_query(0, 0);
      checks++;
      if (bus.chk_ack !== 1'b1 || bus.chk_val !== 2'd0) begin
         failures++;
         $display("FAIL reset_query ack=%b val=%0d want ack=1 val=0", bus.chk_ack, bus.chk_val);
      end
   endtask

   task automatic test_write_scan;
      do_write(10, 5, 2'd1);
      for (int x = 80; x <= 87; x++) begin
         scan_pixel(x, 40);
         checks++;
         if ({out_r, out_g, out_b} !== 24'hFFFF00) begin
            failures++;
            $display("FAIL scan_j1 x=%0d got=%h want=ffff00", x, {out_r, out_g, out_b});
         end
      end
      scan_pixel(88, 40);
      checks++;
      if ({out_r, out_g, out_b} !== 24'h000000) begin
         failures++;
         $display("FAIL scan_neighbour got=%h want=000000", {out_r, out_g, out_b});
      end
      do_write(79, 5, 2'd3);
      scan_pixel(640, 40);
      checks++;
      if ({out_r, out_g, out_b} !== 24'h000000) begin
         failures++;
         $display("FAIL scan_offscreen got=%h want=000000", {out_r, out_g, out_b});
      end
   endtask

   task automatic test_query;
      do_query(10, 5);
      checks++;
      if (bus.chk_ack !== 1'b1 || bus.chk_val !== 2'd1) begin
         failures++;
         $display("FAIL query_j1 ack=%b val=%0d want ack=1 val=1", bus.chk_ack, bus.chk_val);
      end
      tick();
      checks++;
      if (bus.chk_ack !== 1'b0) begin
         failures++;
         $display("FAIL query_pulse ack=%b want=0", bus.chk_ack);
      end
      do_query(80, 0);
      checks++;
      if (bus.chk_ack !== 1'b1 || bus.chk_val !== 2'd3) begin
         failures++;
         $display("FAIL query_oor ack=%b val=%0d want ack=1 val=3", bus.chk_ack, bus.chk_val);
      end
      do_write(80, 0, 2'd2);
      do_query(79, 0);
      checks++;
      if (bus.chk_val !== 2'd0) begin
         failures++;
         $display("FAIL query_dropped_write val=%0d want=0", bus.chk_val);
      end
      bus.chk_req = 1'b1;
      bus.chk_col = 7'd10;
      bus.chk_row = 6'd5;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.chk_ack !== 1'b1 || bus.chk_val !== 2'd1) begin
            failures++;
            $display("FAIL query_held cycle=%0d ack=%b val=%0d want ack=1 val=1", i, bus.chk_ack, bus.chk_val);
         end
      end
      bus.chk_req = 1'b0;
   endtask

   task automatic test_simultaneous;
      bus.wr_en   = 1'b1;
      bus.wr_col  = 7'd3;
      bus.wr_row  = 6'd3;
      bus.wr_val  = 2'd2;
      bus.chk_req = 1'b1;
      bus.chk_col = 7'd3;
      bus.chk_row = 6'd3;
      tick();
      bus.wr_en   = 1'b0;
      bus.chk_req = 1'b0;
      model[3][3] = 2'd2;
      checks++;
      if (bus.chk_ack !== 1'b1 || bus.chk_val !== 2'd0) begin
         failures++;
         $display("FAIL rbw_old ack=%b val=%0d want ack=1 val=0", bus.chk_ack, bus.chk_val);
      end
      do_query(3, 3);
      checks++;
      if (bus.chk_val !== 2'd2) begin
         failures++;
         $display("FAIL rbw_new val=%0d want=2", bus.chk_val);
      end
      scan_pixel(24, 24);
      checks++;
      if ({out_r, out_g, out_b} !== 24'h00FFFF) begin
         failures++;
         $display("FAIL scan_j2 got=%h want=00ffff", {out_r, out_g, out_b});
      end
   endtask

   task automatic test_random;
      int wc, wr, cc, cr;
      logic do_wr, do_chk;
      logic [1:0] wv, exp_val;
      logic [23:0] prev_exp, cur_exp;
      int x, y;
      for (int i = 0; i < 400; i++) begin
         do_wr  = 1'($urandom_range(0, 1));
         do_chk = 1'($urandom_range(0, 1));
         wc = $urandom_range(0, 84);
         wr = $urandom_range(0, 63);
         wv = 2'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            cc = wc;
            cr = wr;
         end else begin
            cc = $urandom_range(0, 84);
            cr = $urandom_range(0, 63);
         end
         bus.wr_en   = do_wr;
         bus.wr_col  = 7'(wc);
         bus.wr_row  = 6'(wr);
         bus.wr_val  = wv;
         bus.chk_req = do_chk;
         bus.chk_col = 7'(cc);
         bus.chk_row = 6'(cr);
         exp_val = (cc < 80 && cr < 60) ? model[cr][cc] : 2'd3;
         if (do_wr && wc < 80 && wr < 60) model[wr][wc] = wv;
         tick();
         checks++;
         if (bus.chk_ack !== do_chk || (do_chk && bus.chk_val !== exp_val)) begin
            failures++;
            $display("FAIL rand_query i=%0d ack=%b val=%0d want ack=%b val=%0d",
                     i, bus.chk_ack, bus.chk_val, do_chk, exp_val);
         end
      end
      idle_inputs();
      tick();
      prev_exp = 24'h0;
      for (int i = 0; i < 300; i++) begin
         x = $urandom_range(0, 700);
         y = $urandom_range(0, 520);
         next_x = 10'(x);
         next_y = 10'(y);
         cur_exp = exp_rgb(x, y);
         tick();
         if (i > 0) begin
            checks++;
            if ({out_r, out_g, out_b} !== prev_exp) begin
               failures++;
               $display("FAIL rand_scan i=%0d got=%h want=%h", i, {out_r, out_g, out_b}, prev_exp);
            end
         end
         prev_exp = cur_exp;
      end
      tick();
      checks++;
      if ({out_r, out_g, out_b} !== prev_exp) begin
         failures++;
         $display("FAIL rand_scan_last got=%h want=%h", {out_r, out_g, out_b}, prev_exp);
      end
   endtask

   task automatic test_restart;
      int cnt;
      int ack_seen;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      model_clear();
      repeat (2000) tick();
      reiniciar = 1'b1;
      tick();
      reiniciar   = 1'b0;
      bus.wr_en   = 1'b1;
      bus.wr_col  = 7'd5;
      bus.wr_row  = 6'd5;
      bus.wr_val  = 2'd1;
      bus.chk_req = 1'b1;
      bus.chk_col = 7'd5;
      bus.chk_row = 6'd5;
      cnt = busy ? 1 : 0;
      ack_seen = 0;
      while (busy && cnt < 10000) begin
         tick();
         if (busy) cnt++;
         if (bus.chk_ack === 1'b1) ack_seen++;
      end
      idle_inputs();
      checks++;
      if (cnt !== 4800) begin
         failures++;
         $display("FAIL restart_busy_len got=%0d want=4800", cnt);
      end
      checks++;
      if (ack_seen !== 0) begin
         failures++;
         $display("FAIL restart_no_ack got=%0d acks want=0", ack_seen);
      end
      do_query(5, 5);
      checks++;
      if (bus.chk_ack !== 1'b1 || bus.chk_val !== 2'd0) begin
         failures++;
         $display("FAIL restart_no_write ack=%b val=%0d want ack=1 val=0", bus.chk_ack, bus.chk_val);
      end
   endtask

   task automatic test_wall_reset;
      int n;
      do_write(0, 0, 2'd3);
      scan_pixel(0, 0);
      checks++;
      if ({out_r, out_g, out_b} !== 24'hFF0000) begin
         failures++;
         $display("FAIL scan_wall got=%h want=ff0000", {out_r, out_g, out_b});
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++;
      if ({out_r, out_g, out_b} !== 24'h0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL midround_reset rgb=%h busy=%b want rgb=0 busy=1", {out_r, out_g, out_b}, busy);
      end
      wait_idle(n);
      model_clear();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL midround_sweep_timeout busy=%b after %0d cycles want=0", busy, n);
      end
      scan_pixel(0, 0);
      checks++;
      if ({out_r, out_g, out_b} !== 24'h0) begin
         failures++;
         $display("FAIL midround_scan got=%h want=000000", {out_r, out_g, out_b});
      end
      do_query(0, 0);
      checks++;
      if (bus.chk_val !== 2'd0) begin
         failures++;
         $display("FAIL midround_query val=%0d want=0", bus.chk_val);
      end
   endtask

   initial begin
      reset  = 1'b0;
      next_x = '0;
      next_y = '0;
      idle_inputs();
      model_clear();
      test_reset();
      test_write_scan();
      test_query();
      test_simultaneous();
      test_random();
      test_restart();
      test_wall_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arena_leitor.md
Name: arena_leitor

Overview:
- Owns the 80x60 arena cell map (2 bits per cell, 8x8-pixel cells over 640x480).
- Reader side of the trail-grid interface. Player logic writes trail cells and queries cells for collisions; the VGA scan reads cells to produce pixel colour.
- Colour outputs feed the VGA colour mux alongside border and sprite layers.
- Includes a clear sweep for reset and for restarting a round.

Parameters:
- COLS, 80, cells per row
- ROWS, 60, cell rows
- CELL_SHIFT, 3, log2 of cell size in pixels
- H_PIX, 640, visible width
- V_PIX, 480, visible height

Ports:
- VGA_CLK  in  1  single clock, pixel clock
- reset  in  1  synchronous, active-low
- reiniciar  in  1  level; starts or restarts the clear sweep
- wr_en  in  1  cell write strobe
- wr_col  in  7  write column
- wr_row  in  6  write row
- wr_val  in  2  value to write
- chk_req  in  1  collision query strobe
- chk_col  in  7  query column
- chk_row  in  6  query row
- chk_ack  out  1  query result valid, one-cycle pulse
- chk_val  out  2  queried cell value
- next_x  in  10  x of next pixel, from the vga block
- next_y  in  10  y of next pixel
- OUT_R  out  8  red
- OUT_G  out  8  green
- OUT_B  out  8  blue
- busy  out  1  clear sweep in progress

Behaviour:
- Clock, reset and width rules
  - One clock (VGA_CLK). Reset is synchronous and active-low: sampled on the VGA_CLK edge while low.
  - Cell address = row*80 + col, computed as (row<<6)+(row<<4)+col, 13 bits.
- Cell codes
  - 0 empty: black (0,0,0)
  - 1 player 1: (255,255,0)
  - 2 player 2: (0,255,255)
  - 3 wall: (255,0,0)
- Reset values: OUT_R/G/B=0, chk_ack=0, chk_val=0, busy=1, FSM=CLEAR, clr_addr=0.
- FSM states: CLEAR, IDLE.
  - CLEAR:
    - Writes 0 to clr_addr each cycle, then increments.
    - At clr_addr=4799 the write happens and the FSM goes to IDLE on the next edge. Total sweep is 4800 cycles with busy=1.
    - reiniciar high in CLEAR resets clr_addr to 0, restarting the full 4800-cycle sweep.
  - IDLE:
    - busy=0.
    - reiniciar high: go to CLEAR with clr_addr=0.
- Write port (IDLE only)
  - wr_en with col<80 and row<60 writes wr_val; visible to reads from the next cycle.
  - Out-of-range writes are dropped.
  - wr_en during CLEAR is ignored.
- Query port (IDLE only)
  - chk_req sampled at edge N gives chk_ack=1 and chk_val at edge N+1, for one cycle.
  - Read-before-write: a same-cycle wr_en to the same cell returns the old value.
  - Out-of-range col/row returns 3 (wall) with no RAM access.
  - chk_req during CLEAR is not acknowledged and is dropped. The requester retries after busy falls.
  - A continuously held chk_req produces an ack every cycle.
- Scan read
  - next_x/next_y are sampled at edge N; colour is registered at edge N+2, a fixed 2-cycle latency.
    - Stage 1: compute address from x>>3, y>>3 and register an out-of-range flag (x>=640 or y>=480).
    - Stage 2: RAM data maps to colour.
  - Out-of-range pixels give black.
  - busy=1 forces black, with the force also pipelined by 2.
- Reset asserted mid-sweep or mid-query: outputs return to reset values and the sweep restarts from 0.

Decomposition:
- Package arena_pkg:
  - COLS, ROWS, CELLS=4800
  - cell codes CELL_VAZIO=0, CELL_J1=1, CELL_J2=2, CELL_PAREDE=3
  - colour constants for each code
- Sub-module arena_ram: 4800x2 simple dual-port synchronous RAM, inferred into block RAM.
  - Port A: read-before-write, shared by write/query and the clear sweep (sweep has priority).
  - Port B: read-only, for the scan.

Test Plan:
- Reset → busy:
  - reset low for 1 cycle, then high → busy=1 for exactly 4800 cycles, then 0.
  - OUT_R/G/B=0 throughout.
  - Query at (0,0) afterwards returns 0.
- Write then scan:
  - Write (10,5)=1, then scan next_x=80..87, next_y=40 → 2 cycles later OUT=(255,255,0).
  - next_x=88 → (0,0,0).
  - next_x=640 → (0,0,0).
- Query port:
  - chk (10,5) → chk_ack=1 next cycle with chk_val=1.
  - chk (80,0) → chk_val=3.
  - wr (80,0)=2 → dropped; chk (79,0) returns 0.
- Simultaneous write and query:
  - Same cycle: wr (3,3)=2 and chk (3,3) → chk_val=0.
  - Re-query → chk_val=2.
  - Scan of pixel (24,24) → (0,255,255).
- Restart mid-sweep:
  - After reset release, hold reiniciar high for one cycle when clr_addr=2000 → busy stays 1 for 4800 further cycles.
  - wr_en and chk_req during busy → no write, no chk_ack.
- Wall cell and reset mid-round:
  - Write (0,0)=3 → scan of pixel (0,0) gives (255,0,0).
  - Then reset low mid-round → OUT=0, busy=1, and cell (0,0) reads 0 after the sweep.
